// File: rtl/ysyx_24090013_ifu_pkg.sv
// Shared constants and FSM encoding for the instruction fetch unit.
package ysyx_24090013_ifu_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } ifu_state_e;

  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_24090013_fetch_fifo.sv
// Fetch buffer: power-of-two FIFO with simultaneous push/pop and a flush that empties it.
module ysyx_24090013_fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_data,
  input  logic                           i_pop,
  input  logic                           i_flush,
  output logic [WIDTH-1:0]               o_data,
  output logic [$clog2(DEPTH+1)-1:0]     o_count,
  output logic                           o_empty,
  output logic                           o_full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // A push into a full buffer is legal only when the head leaves in the same cycle.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

// File: rtl/ysyx_24090013_ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time and buffers {pc, inst} for decode.
module ysyx_24090013_ifu
  import ysyx_24090013_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_mem_req_valid,
  output logic [31:0] ifu_mem_req_addr,
  input  logic        mem_ifu_req_ready,
  input  logic        mem_ifu_resp_valid,
  input  logic [31:0] mem_ifu_resp_data,
  output logic        ifu_mem_resp_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ifu_idu_valid,
  output logic [31:0] ifu_idu_inst,
  output logic [31:0] ifu_idu_pc,
  input  logic        idu_ifu_ready
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  ifu_state_e          r_state;
  ifu_state_e          w_state_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_next;
  logic [ADDR_W-1:0]   r_tag_pc;
  logic [ADDR_W-1:0]   w_tag_next;
  logic                w_req_fire;
  logic                w_resp_fire;
  logic                w_push;
  logic                w_pop;
  logic                w_empty;
  logic                w_full;
  logic [CNT_W-1:0]    w_count;
  logic [63:0]         w_head;
  logic                w_unused;

  assign ifu_mem_req_valid  = (r_state == S_REQ) & ~w_full;
  assign ifu_mem_req_addr   = r_pc;
  assign ifu_mem_resp_ready = (r_state == S_WAIT) | (r_state == S_DRAIN);

  assign w_req_fire  = ifu_mem_req_valid & mem_ifu_req_ready;
  assign w_resp_fire = ifu_mem_resp_ready & mem_ifu_resp_valid;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_tag_next   = r_tag_pc;
    unique case (r_state)
      S_IDLE:  w_state_next = S_REQ;
      S_REQ: begin
        if (w_req_fire) begin
          w_tag_next   = r_pc;
          w_pc_next    = r_pc + 32'd4;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT:  if (w_resp_fire) w_state_next = S_REQ;
      S_DRAIN: if (w_resp_fire) w_state_next = S_REQ;
      default: w_state_next = S_IDLE;
    endcase
    // A response still owed to a flushed fetch must be swallowed in S_DRAIN.
    if (redirect_valid) begin
      w_pc_next = align_word(redirect_pc);
      if ((r_state == S_WAIT && !w_resp_fire) || (r_state == S_REQ && w_req_fire)) begin
        w_state_next = S_DRAIN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_tag_pc <= RESET_PC;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_tag_pc <= w_tag_next;
    end
  end

  assign w_push = (r_state == S_WAIT) & w_resp_fire & ~redirect_valid;
  assign w_pop  = ifu_idu_valid & idu_ifu_ready;

  ysyx_24090013_fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_push  (w_push),
    .i_data  ({r_tag_pc, mem_ifu_resp_data}),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign ifu_idu_valid = ~w_empty;
  assign ifu_idu_pc    = w_head[63:32];
  assign ifu_idu_inst  = w_head[31:0];

  assign w_unused = ^{w_count, redirect_pc[1:0]};

endmodule

// File: tb/tb_ysyx_24090013_ifu.sv
// Self-checking bench for ysyx_24090013_ifu: scoreboarded decode stream plus redirect/reset scenarios.
module tb_ysyx_24090013_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, resp_valid, resp_ready;
  logic [31:0] req_addr, resp_data;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        idu_valid, idu_ready;
  logic [31:0] idu_inst, idu_pc;

  logic        wr_req_valid, wr_resp_valid, wr_resp_ready, wr_idu_valid;
  logic [31:0] wr_req_addr, wr_idu_inst, wr_idu_pc, wr_resp_data;
  logic        wr_pend;
  logic [31:0] wr_paddr;
  logic [31:0] wr_log[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_acc = 0;
  logic [63:0] exp_q[$];
  int          hs_t[$];
  logic [63:0] exp_e;
  logic        pend;
  logic [31:0] paddr;
  logic        resp_en;

  always #5 clk = ~clk;

  ysyx_24090013_ifu u_dut (
    .clk                (clk),
    .rst                (rst),
    .ifu_mem_req_valid  (req_valid),
    .ifu_mem_req_addr   (req_addr),
    .mem_ifu_req_ready  (req_ready),
    .mem_ifu_resp_valid (resp_valid),
    .mem_ifu_resp_data  (resp_data),
    .ifu_mem_resp_ready (resp_ready),
    .redirect_valid     (redir_valid),
    .redirect_pc        (redir_pc),
    .ifu_idu_valid      (idu_valid),
    .ifu_idu_inst       (idu_inst),
    .ifu_idu_pc         (idu_pc),
    .idu_ifu_ready      (idu_ready)
  );

  ysyx_24090013_ifu #(
    .RESET_PC  (32'hFFFF_FFFC),
    .BUF_DEPTH (2)
  ) u_wrap (
    .clk                (clk),
    .rst                (rst),
    .ifu_mem_req_valid  (wr_req_valid),
    .ifu_mem_req_addr   (wr_req_addr),
    .mem_ifu_req_ready  (1'b1),
    .mem_ifu_resp_valid (wr_resp_valid),
    .mem_ifu_resp_data  (wr_resp_data),
    .ifu_mem_resp_ready (wr_resp_ready),
    .redirect_valid     (1'b0),
    .redirect_pc        (32'h0),
    .ifu_idu_valid      (wr_idu_valid),
    .ifu_idu_inst       (wr_idu_inst),
    .ifu_idu_pc         (wr_idu_pc),
    .idu_ifu_ready      (1'b1)
  );

  // Responder model: one response a cycle after acceptance, held back while resp_en is low.
  assign resp_valid = pend & resp_en;
  assign resp_data  = paddr ^ 32'hFFFF_0000;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= 1'b0;
    end else begin
      if (resp_valid && resp_ready) pend <= 1'b0;
      if (req_valid && req_ready) begin
        pend  <= 1'b1;
        paddr <= req_addr;
        n_acc <= n_acc + 1;
      end
    end
  end

  assign wr_resp_valid = wr_pend;
  assign wr_resp_data  = wr_paddr ^ 32'hFFFF_0000;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_pend <= 1'b0;
    end else begin
      if (wr_resp_valid && wr_resp_ready) wr_pend <= 1'b0;
      if (wr_req_valid) begin
        wr_pend  <= 1'b1;
        wr_paddr <= wr_req_addr;
        if (wr_log.size() < 4) wr_log.push_back(wr_req_addr);
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Decode-side scoreboard: every handshake must match the oldest expected {pc, inst}.
  always @(negedge clk) begin
    if (rst && idu_valid && idu_ready) begin
      n_checks++;
      hs_t.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL decode_unexpected: got pc=%h inst=%h, required no handshake", idu_pc, idu_inst);
      end else begin
        exp_e = exp_q.pop_front();
        if ({idu_pc, idu_inst} !== exp_e) begin
          n_errors++;
          $display("FAIL decode_pair: got pc=%h inst=%h, required pc=%h inst=%h",
                   idu_pc, idu_inst, exp_e[63:32], exp_e[31:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({pc + 32'(4 * i), (pc + 32'(4 * i)) ^ 32'hFFFF_0000});
    end
  endtask

  task automatic drain_exp(input string name);
    idu_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    idu_ready = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_timeout: got %0d pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic settle;
    idu_ready = 1'b0;
    resp_en   = 1'b1;
    repeat (10) tick();
    exp_q.delete();
  endtask

  task automatic test_reset;
    repeat (2) tick();
    n_checks += 6;
    if (req_valid !== 1'b0) begin n_errors++; $display("FAIL rst_req_valid: got %b required 0", req_valid); end
    if (resp_ready !== 1'b0) begin n_errors++; $display("FAIL rst_resp_ready: got %b required 0", resp_ready); end
    if (idu_valid !== 1'b0) begin n_errors++; $display("FAIL rst_idu_valid: got %b required 0", idu_valid); end
    if (req_addr !== 32'h8000_0000) begin n_errors++; $display("FAIL rst_addr: got %h required 80000000", req_addr); end
    if (idu_inst !== 32'h0) begin n_errors++; $display("FAIL rst_inst: got %h required 0", idu_inst); end
    if (idu_pc !== 32'h0) begin n_errors++; $display("FAIL rst_pc: got %h required 0", idu_pc); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (req_valid !== 1'b0) begin n_errors++; $display("FAIL idle_req: got %b required 0", req_valid); end
    tick();
    n_checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000) begin
      n_errors++;
      $display("FAIL first_req: got v=%b a=%h required v=1 a=80000000", req_valid, req_addr);
    end
  endtask

  task automatic test_backpressure;
    push_exp(32'h8000_0000, 2);
    repeat (12) tick();
    n_checks += 3;
    if (n_acc !== 2) begin n_errors++; $display("FAIL bp_accepts: got %0d required 2", n_acc); end
    if (req_valid !== 1'b0) begin n_errors++; $display("FAIL bp_req_held: got %b required 0", req_valid); end
    if (idu_valid !== 1'b1 || idu_pc !== 32'h8000_0000) begin
      n_errors++;
      $display("FAIL bp_head: got v=%b pc=%h required v=1 pc=80000000", idu_valid, idu_pc);
    end
    idu_ready = 1'b1;
    tick();
    idu_ready = 1'b0;
    n_checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h8000_0008) begin
      n_errors++;
      $display("FAIL bp_req_after_pop: got v=%b a=%h required v=1 a=80000008", req_valid, req_addr);
    end
  endtask

  task automatic test_stream;
    push_exp(32'h8000_0008, 6);
    drain_exp("stream");
    n_checks++;
    if (hs_t.size() < 3 || hs_t[hs_t.size()-1] - hs_t[hs_t.size()-2] != 2 ||
        hs_t[hs_t.size()-2] - hs_t[hs_t.size()-3] != 2) begin
      n_errors++;
      $display("FAIL stream_rate: got last handshake spacing not 2 (n=%0d), required 2", hs_t.size());
    end
  endtask

  task automatic test_redirect_wait;
    settle();
    resp_en = 1'b0;
    redir_valid = 1'b1; redir_pc = 32'h8000_0800;
    tick();
    redir_valid = 1'b0;
    n_checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h8000_0800) begin
      n_errors++;
      $display("FAIL rw_flush_req: got v=%b a=%h required v=1 a=80000800", req_valid, req_addr);
    end
    tick();
    n_checks++;
    if (resp_ready !== 1'b1) begin n_errors++; $display("FAIL rw_wait: got %b required 1", resp_ready); end
    redir_valid = 1'b1; redir_pc = 32'h8000_1003;
    tick();
    redir_valid = 1'b0;
    n_checks++;
    if (req_valid !== 1'b0 || resp_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rw_drain: got rv=%b rr=%b required rv=0 rr=1", req_valid, resp_ready);
    end
    resp_en = 1'b1;
    tick();
    n_checks++;
    if (idu_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h8000_1000) begin
      n_errors++;
      $display("FAIL rw_next_req: got iv=%b v=%b a=%h required iv=0 v=1 a=80001000",
               idu_valid, req_valid, req_addr);
    end
    push_exp(32'h8000_1000, 2);
    drain_exp("rw");
  endtask

  task automatic test_redirect_handshake;
    settle();
    resp_en = 1'b0;
    redir_valid = 1'b1; redir_pc = 32'h8000_2000;
    tick();
    redir_pc = 32'h8000_3000;
    tick();
    n_checks++;
    if (req_valid !== 1'b0 || resp_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rh_drain: got rv=%b rr=%b required rv=0 rr=1", req_valid, resp_ready);
    end
    redir_pc = 32'h8000_4000;
    tick();
    redir_valid = 1'b0;
    n_checks++;
    if (req_valid !== 1'b0 || resp_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rh_stay_drain: got rv=%b rr=%b required rv=0 rr=1", req_valid, resp_ready);
    end
    resp_en = 1'b1;
    tick();
    n_checks++;
    if (idu_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h8000_4000) begin
      n_errors++;
      $display("FAIL rh_next_req: got iv=%b v=%b a=%h required iv=0 v=1 a=80004000",
               idu_valid, req_valid, req_addr);
    end
    push_exp(32'h8000_4000, 2);
    drain_exp("rh");
  endtask

  task automatic test_redirect_pop_resp;
    repeat (10) tick();
    push_exp(32'h8000_4008, 1);
    idu_ready = 1'b1;
    redir_valid = 1'b1; redir_pc = 32'h8000_5000;
    tick();
    idu_ready = 1'b0;
    redir_valid = 1'b0;
    n_checks++;
    if (idu_valid !== 1'b0 || exp_q.size() != 0 || req_addr !== 32'h8000_5000) begin
      n_errors++;
      $display("FAIL rp_flush: got iv=%b pend=%0d a=%h required iv=0 pend=0 a=80005000",
               idu_valid, exp_q.size(), req_addr);
    end
    tick();
    redir_valid = 1'b1; redir_pc = 32'h8000_6000;
    tick();
    redir_valid = 1'b0;
    n_checks++;
    if (idu_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h8000_6000) begin
      n_errors++;
      $display("FAIL rr_resp_drop: got iv=%b v=%b a=%h required iv=0 v=1 a=80006000",
               idu_valid, req_valid, req_addr);
    end
    push_exp(32'h8000_6000, 1);
    drain_exp("rr");
  endtask

  task automatic test_wrap;
    n_checks += 2;
    if (wr_log.size() < 2 || wr_log[0] !== 32'hFFFF_FFFC) begin
      n_errors++;
      $display("FAIL wrap_first: got n=%0d required a=fffffffc", wr_log.size());
    end
    if (wr_log.size() < 2 || wr_log[1] !== 32'h0000_0000) begin
      n_errors++;
      $display("FAIL wrap_second: got n=%0d required a=00000000", wr_log.size());
    end
  endtask

  task automatic test_reset_midway;
    settle();
    redir_valid = 1'b1; redir_pc = 32'h8000_7000;
    tick();
    redir_valid = 1'b0;
    tick();
    tick();
    resp_en = 1'b0;
    tick();
    n_checks++;
    if (idu_valid !== 1'b1 || resp_ready !== 1'b1 || idu_pc !== 32'h8000_7000) begin
      n_errors++;
      $display("FAIL mr_setup: got iv=%b rr=%b pc=%h required iv=1 rr=1 pc=80007000",
               idu_valid, resp_ready, idu_pc);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (req_valid !== 1'b0 || resp_ready !== 1'b0 || idu_valid !== 1'b0 ||
        req_addr !== 32'h8000_0000 || idu_inst !== 32'h0 || idu_pc !== 32'h0) begin
      n_errors++;
      $display("FAIL mr_outputs: got rv=%b rr=%b iv=%b a=%h i=%h p=%h required 0 0 0 80000000 0 0",
               req_valid, resp_ready, idu_valid, req_addr, idu_inst, idu_pc);
    end
    tick();
    rst = 1'b1;
    resp_en = 1'b1;
    tick();
    n_checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000) begin
      n_errors++;
      $display("FAIL mr_restart: got v=%b a=%h required v=1 a=80000000", req_valid, req_addr);
    end
  endtask

  initial begin
    rst         = 1'b1;
    req_ready   = 1'b1;
    resp_en     = 1'b1;
    redir_valid = 1'b0;
    redir_pc    = 32'h0;
    idu_ready   = 1'b0;
    #2 rst = 1'b0;
    test_reset();
    test_backpressure();
    test_stream();
    test_redirect_wait();
    test_redirect_handshake();
    test_redirect_pop_resp();
    test_wrap();
    test_reset_midway();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
